// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-RAM port arbiter: FSM states, transfer size codes, grant owners.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  // Size code 11 behaves as a word.
  function automatic logic [2:0] size_to_nbytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_to_nbytes = 3'd1;
      SZ_HALF: size_to_nbytes = 3'd2;
      SZ_WORD: size_to_nbytes = 3'd4;
      default: size_to_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on the next contention.
module rr_arb2
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       valid_o,
  output logic       gnt_o
);

  logic ptr_q;

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) gnt_o = ptr_q;
    else                gnt_o = req_i[1] ? GNT_LD : GNT_CPU;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  ptr_q <= 1'(FIRST_PRIO);
    else if (accept_i && valid_o) ptr_q <= ~gnt_o;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises CPU and loader 8/16/32-bit big-endian requests onto a byte-wide RAM, one byte per cycle.
module ram_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_rw,
  input  logic [1:0]        ld_size,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_done,
  output logic [31:0]       ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy,
  output logic              grant
);

  state_e            state_q;
  logic              rw_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [31:0]       wsh_q;
  logic [31:0]       acc_q;
  logic [31:0]       acc_d;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       ld_rdata_q;
  logic              cpu_done_q;
  logic              ld_done_q;
  logic              busy_q;
  logic              grant_q;

  logic              arb_valid;
  logic              arb_gnt;
  logic              sel_rw;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_n;
  logic [5:0]        sel_shamt;

  rr_arb2 #(.FIRST_PRIO(FIRST_PRIO)) u_arb (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .req_i    ({ld_req, cpu_req}),
    .accept_i (state_q == ST_IDLE),
    .valid_o  (arb_valid),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    if (arb_gnt == GNT_LD) begin
      sel_rw    = ld_rw;
      sel_size  = ld_size;
      sel_addr  = ld_addr;
      sel_wdata = ld_wdata;
    end else begin
      sel_rw    = cpu_rw;
      sel_size  = cpu_size;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
    sel_n     = size_to_nbytes(sel_size);
    sel_shamt = {3'd4 - sel_n, 3'b000};
    acc_d     = {acc_q[23:0], ram_rdata};
  end

  // Write data is left-aligned so the outgoing byte is always bits [31:24]; read
  // bytes shift in from the bottom, which yields a zero-extended big-endian result.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      idx_q       <= '0;
      last_q      <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      wsh_q       <= '0;
      acc_q       <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      cpu_done_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= 1'(FIRST_PRIO);
    end else begin
      case (state_q)
        ST_IDLE: begin
          ram_we_q <= 1'b0;
          if (arb_valid) begin
            grant_q    <= arb_gnt;
            rw_q       <= sel_rw;
            last_q     <= 2'(sel_n - 3'd1);
            idx_q      <= '0;
            ram_addr_q <= sel_addr;
            ram_we_q   <= ~sel_rw;
            wsh_q      <= sel_wdata << sel_shamt;
            acc_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (idx_q == last_q) begin
            ram_we_q <= 1'b0;
            state_q  <= ST_DONE;
            if (grant_q == GNT_LD) begin
              ld_done_q <= 1'b1;
              if (rw_q) ld_rdata_q <= acc_d;
            end else begin
              cpu_done_q <= 1'b1;
              if (rw_q) cpu_rdata_q <= acc_d;
            end
          end else begin
            idx_q      <= idx_q + 2'd1;
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            wsh_q      <= {wsh_q[23:0], 8'h00};
            acc_q      <= acc_d;
          end
        end
        ST_DONE: begin
          cpu_done_q <= 1'b0;
          ld_done_q  <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = wsh_q[31:24];
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_done   = ld_done_q;
  assign ld_rdata  = ld_rdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural byte RAM and hand-computed expectations.
module tb_ram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cpu_req, cpu_rw, ld_req, ld_rw;
  logic [1:0]  cpu_size, ld_size;
  logic [7:0]  cpu_addr, ld_addr;
  logic [31:0] cpu_wdata, ld_wdata;
  logic        cpu_done, ld_done;
  logic [31:0] cpu_rdata, ld_rdata;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, busy, grant;

  logic [7:0]  mem [256] = '{default: 8'h5A};

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  ram_port_arbiter #(.ADDR_W(8), .FIRST_PRIO(0)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_rw(ld_rw), .ld_size(ld_size), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_done(ld_done), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transfer on a single port; returns the cycle (after acceptance) in which done was seen, 0 on timeout.
  task automatic xfer(input logic port, input logic rw, input logic [1:0] sz,
                      input logic [7:0] addr, input logic [31:0] wd, output int lat);
    logic dn;
    @(negedge CLK);
    if (port) begin
      ld_req = 1'b1; ld_rw = rw; ld_size = sz; ld_addr = addr; ld_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_rw = rw; cpu_size = sz; cpu_addr = addr; cpu_wdata = wd;
    end
    @(posedge CLK);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        check("busy_in_xfer", 32'(busy), 32'd1);
        check("grant_owner", 32'(grant), 32'(port));
      end
      dn = port ? ld_done : cpu_done;
      if (dn) begin
        lat = c;
        break;
      end
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    @(negedge CLK);
    dn = port ? ld_done : cpu_done;
    check("done_one_cycle", 32'(dn), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int npulse;
    int nev;
    int overlap;
    logic [1:0] order [3];

    RESET = 1'b0;
    cpu_req = 1'b0; cpu_rw = 1'b0; cpu_size = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 1'b0; ld_rw  = 1'b0; ld_size  = 2'b00; ld_addr  = '0; ld_wdata  = '0;
    repeat (3) @(negedge CLK);
    check("rst_ram_we",    32'(ram_we), 32'd0);
    check("rst_ram_addr",  32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_cpu_done",  32'(cpu_done), 32'd0);
    check("rst_ld_done",   32'(ld_done), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_ld_rdata",  ld_rdata, 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_grant",     32'(grant), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_no_we", 32'(ram_we), 32'd0);

    xfer(1'b0, 1'b0, 2'b10, 8'h10, 32'hDEADBEEF, lat);
    check("wr_word_lat", 32'(lat), 32'd5);
    check("wr_word_ram", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);

    xfer(1'b0, 1'b1, 2'b10, 8'h10, 32'h0, lat);
    check("rd_word_lat", 32'(lat), 32'd5);
    check("rd_word_data", cpu_rdata, 32'hDEADBEEF);

    xfer(1'b0, 1'b1, 2'b00, 8'h13, 32'h0, lat);
    check("rd_byte_lat", 32'(lat), 32'd2);
    check("rd_byte_data", cpu_rdata, 32'h000000EF);

    xfer(1'b0, 1'b0, 2'b01, 8'hFF, 32'h00001234, lat);
    check("wr_half_lat", 32'(lat), 32'd3);
    check("wr_half_ff", 32'(mem[8'hFF]), 32'h12);
    check("wr_half_wrap", 32'(mem[8'h00]), 32'h34);

    xfer(1'b0, 1'b1, 2'b01, 8'hFF, 32'h0, lat);
    check("rd_half_wrap", cpu_rdata, 32'h00001234);

    xfer(1'b0, 1'b1, 2'b11, 8'h10, 32'h0, lat);
    check("rd_sz11_lat", 32'(lat), 32'd5);
    check("rd_sz11_data", cpu_rdata, 32'hDEADBEEF);

    xfer(1'b1, 1'b0, 2'b10, 8'h41, 32'hCAFE0001, lat);
    check("ld_wr_lat", 32'(lat), 32'd5);
    check("ld_wr_ram", {mem[8'h41], mem[8'h42], mem[8'h43], mem[8'h44]}, 32'hCAFE0001);

    xfer(1'b0, 1'b1, 2'b01, 8'h42, 32'h0, lat);
    check("rd_misaligned", cpu_rdata, 32'h0000FE00);

    xfer(1'b1, 1'b1, 2'b00, 8'h44, 32'h0, lat);
    check("ld_rd_byte", ld_rdata, 32'h00000001);
    check("cpu_rdata_held", cpu_rdata, 32'h0000FE00);

    // Request dropped right after acceptance still completes once.
    @(negedge CLK);
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_size = 2'b10; cpu_addr = 8'h10;
    @(posedge CLK);
    #1 cpu_req = 1'b0;
    npulse = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (cpu_done) npulse++;
    end
    check("drop_req_pulses", 32'(npulse), 32'd1);
    check("drop_req_data", cpu_rdata, 32'hDEADBEEF);

    // Reset asserted during the second XFER cycle of a word write.
    @(negedge CLK);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_size = 2'b10; cpu_addr = 8'h20; cpu_wdata = 32'hAABBCCDD;
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(ram_we), 32'd0);
    cpu_req = 1'b0;
    npulse = 0;
    repeat (2) begin
      @(negedge CLK);
      if (cpu_done) npulse++;
    end
    RESET = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      if (cpu_done) npulse++;
    end
    check("abort_no_done", 32'(npulse), 32'd0);
    check("abort_ram", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'hAA5A5A5A);

    // Contention straight after reset: CPU first, then alternate.
    @(negedge CLK);
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_size = 2'b00; cpu_addr = 8'h10;
    ld_req  = 1'b1; ld_rw  = 1'b1; ld_size  = 2'b00; ld_addr  = 8'h13;
    nev = 0;
    overlap = 0;
    order[0] = 2'd3; order[1] = 2'd3; order[2] = 2'd3;
    for (int c = 0; c < 20 && nev < 3; c++) begin
      @(negedge CLK);
      if (cpu_done && ld_done) overlap++;
      if (cpu_done || ld_done) begin
        order[nev] = {1'b0, ld_done};
        nev++;
      end
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    check("rr_events", 32'(nev), 32'd3);
    check("rr_overlap", 32'(overlap), 32'd0);
    check("rr_first_cpu", 32'(order[0]), 32'd0);
    check("rr_second_ld", 32'(order[1]), 32'd1);
    check("rr_third_cpu", 32'(order[2]), 32'd0);
    check("rr_cpu_data", cpu_rdata, 32'h000000DE);
    check("rr_ld_data", ld_rdata, 32'h000000EF);

    repeat (4) @(negedge CLK);
    check("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width (256-byte RAM).
REQ-002 Parameter FIRST_PRIO, default 0, requester favoured on the first cycle after reset (0 = CPU, 1 = loader).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 cpu_req, cpu_rw (1 = read), cpu_size[1:0] (00 byte, 01 halfword, 10 word), cpu_addr[ADDR_W-1:0], cpu_wdata[31:0]  inputs  CPU datapath memory request.
REQ-006 cpu_done  output  1  one-cycle completion pulse (MOC equivalent); cpu_rdata  output  32  read result.
REQ-007 ld_req, ld_rw, ld_size[1:0], ld_addr[ADDR_W-1:0], ld_wdata[31:0] inputs; ld_done (1), ld_rdata (32) outputs: loader/debug port, same semantics.
REQ-008 ram_addr  output  ADDR_W; ram_we  output  1; ram_wdata  output  8; ram_rdata  input  8 (combinational read of the byte RAM).
REQ-009 busy  output  1  high while any transfer is in progress; grant  output  1  owner of the current transfer (0 = CPU, 1 = loader).

Function
REQ-010 FSM states: IDLE, XFER, DONE.
REQ-011 IDLE: with no request, stay in IDLE and drive ram_we = 0.
REQ-012 IDLE arbitration, one request: accept it.
REQ-013 IDLE arbitration, both requests: grant the requester not granted last (round-robin).
REQ-014 On the accepting edge: latch rw, size, addr and wdata; set byte index i = 0; go to XFER.
REQ-015 Byte count N = 1, 2 or 4 by size; size 11 is treated as word.
REQ-016 XFER, per cycle: ram_addr = (addr + i) mod 2^ADDR_W, so 0xFF wraps to 0x00.
REQ-017 XFER write: ram_we = 1 and ram_wdata = byte (N-1-i) of wdata, big-endian (lowest address holds the most-significant byte).
REQ-018 XFER read: ram_we = 0; capture ram_rdata into byte (N-1-i) of the N-byte result at the clock edge.
REQ-019 Read result: zero-extended into rdata[31:0].
REQ-020 i increments each cycle; after the cycle with i = N-1, go to DONE.
REQ-021 DONE: assert the granted port's done for exactly one cycle and hold that port's rdata stable; return to IDLE.
REQ-022 Latency: done is high in cycle N+1 after the accepting edge (word = 5 cycles from acceptance).
REQ-023 A request is accepted again only if req is still high in IDLE.
REQ-024 Requesters hold req and operands stable until done; deasserting req mid-transfer does not abort the transfer.
REQ-025 The non-granted request waits with no side effects and is served on the next IDLE.
REQ-026 Throughput: back-to-back transfers have exactly one IDLE cycle between a DONE and the next XFER.
REQ-027 Misaligned addresses are legal; no alignment fault is generated.
REQ-028 busy = 1 in XFER and DONE, 0 in IDLE.

Reset
REQ-029 RESET low forces IDLE immediately, including mid-XFER: no further writes; partial writes already issued remain in RAM.
REQ-030 Reset values: ram_we = 0, ram_addr = 0, ram_wdata = 0, cpu_done = ld_done = 0, cpu_rdata = ld_rdata = 0, busy = 0, grant = FIRST_PRIO, round-robin pointer = FIRST_PRIO.
REQ-031 An aborted transfer produces no done pulse.

Structure
REQ-032 State encodings, size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the grant codes go in shared package mem_ctrl_pkg.
REQ-033 Sub-module rr_arb2 holds the 2-way round-robin arbiter and its pointer.
REQ-034 The FSM, byte counter and byte-lane steering stay in the top module.

Verification
REQ-035 CPU word write 0xDEADBEEF to 0x10, then word read of 0x10: RAM[0x10..0x13] = DE AD BE EF; cpu_rdata = 0xDEADBEEF; cpu_done pulses 5 cycles after each acceptance.
REQ-036 Byte read of 0x13 after REQ-035: cpu_rdata = 0x000000EF; done 2 cycles after acceptance.
REQ-037 Halfword write 0x1234 to 0xFF: RAM[0xFF] = 0x12 and RAM[0x00] = 0x34 (wrap).
REQ-038 cpu_req and ld_req rise together, both holding: after reset the CPU is served first (FIRST_PRIO = 0), then the loader; grant alternates, and no done pulses overlap.
REQ-039 RESET low in the 2nd XFER cycle of a word write of 0xAABBCCDD to 0x20: RAM[0x20] = AA, RAM[0x21..0x23] unchanged, no cpu_done; busy = 0 immediately.
REQ-040 cpu_req dropped after acceptance: the transfer completes and cpu_done still pulses once.
